// File: rtl/window_invoke_fsm1_pkg.sv
// -----------------------------------------------------------------------------
// window_invoke_fsm1_pkg
// Shared definitions for the window actor's level-1 invoke controller:
//   - CFDF mode encodings (same values the level-2 firing FSM expects)
//   - invoke controller state encodings
//   - log2 helper used to size FIFO population/free-space ports
//   - mode sequencing helper
// -----------------------------------------------------------------------------
package window_invoke_fsm1_pkg;

  typedef enum logic [1:0] {
    MODE_SETUP_COMP = 2'b00,
    MODE_COMP       = 2'b01,
    MODE_OUTPUT     = 2'b10,
    MODE_RSVD       = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_FETCH  = 3'd2,
    S_LATCH  = 3'd3,
    S_START  = 3'd4,
    S_WAIT   = 3'd5,
    S_UPDATE = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  // Smallest r with 2**r >= value (value <= 2**30).
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (value > (32'sd1 <<< i)) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // CFDF mode cycle: SETUP_COMP -> COMP -> OUTPUT -> SETUP_COMP.
  // The unused encoding falls back to SETUP_COMP so the actor can recover.
  function automatic logic [1:0] next_mode(input logic [1:0] mode);
    logic [1:0] nm;
    case (mode)
      MODE_SETUP_COMP: nm = MODE_COMP;
      MODE_COMP:       nm = MODE_OUTPUT;
      MODE_OUTPUT:     nm = MODE_SETUP_COMP;
      default:         nm = MODE_SETUP_COMP;
    endcase
    return nm;
  endfunction

endpackage

// File: rtl/window_enable_check.sv
// -----------------------------------------------------------------------------
// window_enable_check
// Combinational CFDF enable condition of the window actor for a given mode.
// Ports:
//   mode_i           current CFDF mode
//   pop_data_i       population of the input data FIFO
//   pop_length_i     population of the length FIFO
//   pop_command_i    population of the command FIFO
//   free_space_i     free slots in the output FIFO
//   enable_o         1 when the actor may fire in mode_i
// All population comparisons are unsigned over the full PW width.
// -----------------------------------------------------------------------------
module window_enable_check
  import window_invoke_fsm1_pkg::*;
#(
  parameter int size = 3,
  parameter int PW   = 5
) (
  input  logic [1:0]    mode_i,
  input  logic [PW-1:0] pop_data_i,
  input  logic [PW-1:0] pop_length_i,
  input  logic [PW-1:0] pop_command_i,
  input  logic [PW-1:0] free_space_i,
  output logic          enable_o
);

  localparam logic [PW-1:0] SIZE_C = PW'(size);
  localparam logic [PW-1:0] ONE_C  = PW'(1);

  // Per-mode token/space requirements.
  always_comb begin
    enable_o = 1'b0;
    case (mode_i)
      MODE_SETUP_COMP: enable_o = (pop_data_i >= SIZE_C) &&
                                  (pop_length_i >= ONE_C) &&
                                  (pop_command_i >= ONE_C);
      MODE_COMP:       enable_o = 1'b1;
      MODE_OUTPUT:     enable_o = (free_space_i >= ONE_C);
      default:         enable_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/window_invoke_fsm1.sv
// -----------------------------------------------------------------------------
// window_invoke_fsm1
// Level-1 invoke controller for the window computation actor. For each
// scheduler invoke it checks the enable condition of the current mode, fetches
// length/command tokens in SETUP_COMP mode, fires the level-2 firing FSM,
// waits for its done pulse and advances the mode.
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   invoke                   scheduler request pulse (only seen in S_IDLE)
//   pop_in_*/free_space_out  FIFO populations / output free space
//   length_in/command_in     FIFO read data, valid one cycle after rd
//   rd_in_length/command     FIFO read enables (one-cycle pulse)
//   length_out/command_out   tokens latched for the child
//   start_out, mode_out      child fire request and its mode
//   done_in                  child completion pulse (only seen in S_WAIT)
//   enable_out               combinational enable of the current mode
//   fire_done_out, fired_out invoke handled; fired=1 child ran, 0 rejected
// -----------------------------------------------------------------------------
module window_invoke_fsm1
  import window_invoke_fsm1_pkg::*;
#(
  parameter int size        = 3,
  parameter int width       = 10,
  parameter int buffer_size = 16,
  localparam int PW         = log2(buffer_size) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          invoke,
  input  logic [PW-1:0] pop_in_data,
  input  logic [PW-1:0] pop_in_length,
  input  logic [PW-1:0] pop_in_command,
  input  logic [PW-1:0] free_space_out,
  input  logic [1:0]    length_in,
  input  logic [1:0]    command_in,
  output logic          rd_in_length,
  output logic          rd_in_command,
  output logic [1:0]    length_out,
  output logic [1:0]    command_out,
  output logic          start_out,
  output logic [1:0]    mode_out,
  input  logic          done_in,
  output logic          enable_out,
  output logic          fire_done_out,
  output logic          fired_out
);

  // Data width only matters to the child's configuration; nothing here uses it.
  logic [31:0] width_unused_s;
  assign width_unused_s = 32'(width);

  state_e     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [1:0] len_q, len_d;
  logic [1:0] cmd_q, cmd_d;
  logic       flag_q, flag_d;
  logic       rd_q, rd_d;
  logic       start_q, start_d;
  logic       fd_q, fd_d;
  logic       fired_q, fired_d;
  logic       enable_s;

  window_enable_check #(
    .size (size),
    .PW   (PW)
  ) u_enable (
    .mode_i        (mode_q),
    .pop_data_i    (pop_in_data),
    .pop_length_i  (pop_in_length),
    .pop_command_i (pop_in_command),
    .free_space_i  (free_space_out),
    .enable_o      (enable_s)
  );

  // Next-state and datapath updates. Moore outputs are registered from the
  // next state, so they line up exactly with the state they belong to.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cmd_d   = cmd_q;
    flag_d  = flag_q;
    case (state_q)
      S_IDLE: begin
        if (invoke) state_d = S_CHECK;
        else        state_d = S_IDLE;
      end
      S_CHECK: begin
        flag_d = 1'b0;
        if (!enable_s)                      state_d = S_DONE;
        else if (mode_q == MODE_SETUP_COMP) state_d = S_FETCH;
        else                                state_d = S_START;
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        // FIFO read data is valid in the cycle after the read strobe.
        len_d   = length_in;
        cmd_d   = command_in;
        state_d = S_START;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (done_in) state_d = S_UPDATE;
        else         state_d = S_WAIT;
      end
      S_UPDATE: begin
        mode_d  = next_mode(mode_q);
        flag_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rd_d    = (state_d == S_FETCH);
    start_d = (state_d == S_START);
    fd_d    = (state_d == S_DONE);
    fired_d = (state_d == S_DONE) && flag_d;
  end

  // State, mode, token and output registers; reset drops any in-flight firing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_SETUP_COMP;
      len_q   <= 2'b00;
      cmd_q   <= 2'b00;
      flag_q  <= 1'b0;
      rd_q    <= 1'b0;
      start_q <= 1'b0;
      fd_q    <= 1'b0;
      fired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cmd_q   <= cmd_d;
      flag_q  <= flag_d;
      rd_q    <= rd_d;
      start_q <= start_d;
      fd_q    <= fd_d;
      fired_q <= fired_d;
    end
  end

  assign rd_in_length  = rd_q;
  assign rd_in_command = rd_q;
  assign length_out    = len_q;
  assign command_out   = cmd_q;
  assign start_out     = start_q;
  assign mode_out      = mode_q;
  assign enable_out    = enable_s;
  assign fire_done_out = fd_q;
  assign fired_out     = fired_q;

endmodule

// File: tb/tb_window_invoke_fsm1.sv
// -----------------------------------------------------------------------------
// tb_window_invoke_fsm1
// Transaction-level bench for the window invoke controller. A reference model
// tracks the CFDF mode and latched tokens; each invoke is judged on when the
// FIFO reads, start pulse and fire_done pulse appear relative to the invoke.
// -----------------------------------------------------------------------------
module tb_window_invoke_fsm1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       invoke = 1'b0;
  logic [4:0] pop_in_data = 5'd0, pop_in_length = 5'd0, pop_in_command = 5'd0, free_space_out = 5'd0;
  logic [1:0] length_in = 2'd0, command_in = 2'd0;
  logic       rd_in_length, rd_in_command, start_out, enable_out, fire_done_out, fired_out;
  logic [1:0] length_out, command_out, mode_out;
  logic       done_in = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_mode = 0;
  int m_len  = 0;
  int m_cmd  = 0;

  window_invoke_fsm1 dut (
    .clk(clk), .rst(rst), .invoke(invoke),
    .pop_in_data(pop_in_data), .pop_in_length(pop_in_length),
    .pop_in_command(pop_in_command), .free_space_out(free_space_out),
    .length_in(length_in), .command_in(command_in),
    .rd_in_length(rd_in_length), .rd_in_command(rd_in_command),
    .length_out(length_out), .command_out(command_out),
    .start_out(start_out), .mode_out(mode_out), .done_in(done_in),
    .enable_out(enable_out), .fire_done_out(fire_done_out), .fired_out(fired_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // CFDF enable rules of the window actor, size = 3.
  function automatic int model_en();
    case (m_mode)
      0:       return (int'(pop_in_data) >= 3 && int'(pop_in_length) >= 1 && int'(pop_in_command) >= 1) ? 1 : 0;
      1:       return 1;
      2:       return (int'(free_space_out) >= 1) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // One scheduler invoke. dly = extra cycles the child spends before done;
  // noise adds ignored invoke/done pulses around the firing.
  task automatic do_invoke(input int dly, input bit noise, input logic [1:0] tl, input logic [1:0] tc);
    int  exp_en, setup, exp_st, exp_len, exp_cmd;
    int  rd_cnt, rd_cyc, rdc_cnt, st_cnt, st_cyc, fd_cnt, fd_cyc, fd_fired, done_cyc;
    bit  rd_prev;
    exp_en  = model_en();
    setup   = (m_mode == 0) ? 1 : 0;
    exp_st  = setup ? 4 : 2;
    exp_len = (exp_en == 1 && setup == 1) ? int'(tl) : m_len;
    exp_cmd = (exp_en == 1 && setup == 1) ? int'(tc) : m_cmd;
    rd_cnt = 0; rd_cyc = -1; rdc_cnt = 0; st_cnt = 0; st_cyc = -1;
    fd_cnt = 0; fd_cyc = -1; fd_fired = -1; done_cyc = -1; rd_prev = 1'b0;

    @(posedge clk); #1;
    invoke  = 1'b1;
    done_in = noise;
    @(negedge clk);
    check("enable_out", enable_out, exp_en);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (st_cyc >= 0 && done_cyc < 0) done_cyc = st_cyc + 1 + dly;
      invoke  = noise && (c == 1 || (st_cyc >= 0 && c >= st_cyc && c <= done_cyc));
      done_in = (done_cyc >= 0 && c == done_cyc) || (noise && (c == 1 || (fd_cyc >= 0 && c == fd_cyc + 1)));
      length_in  = rd_prev ? tl : 2'($urandom);
      command_in = rd_prev ? tc : 2'($urandom);
      @(negedge clk);
      rd_prev = rd_in_length;
      if (rd_in_length) begin
        rd_cnt++;
        if (rd_cyc < 0) rd_cyc = c;
      end
      if (rd_in_command) rdc_cnt++;
      if (start_out) begin
        st_cnt++;
        if (st_cyc < 0) begin
          st_cyc = c;
          check("mode_at_start", mode_out, m_mode);
          check("length_at_start", length_out, exp_len);
          check("command_at_start", command_out, exp_cmd);
        end
      end
      if (fire_done_out) begin
        fd_cnt++;
        if (fd_cyc < 0) begin
          fd_cyc   = c;
          fd_fired = fired_out;
        end
      end
      if (fd_cyc >= 0 && c >= fd_cyc + 3) break;
    end
    invoke  = 1'b0;
    done_in = 1'b0;

    check("rd_length_count", rd_cnt, (exp_en == 1 && setup == 1) ? 1 : 0);
    check("rd_command_count", rdc_cnt, (exp_en == 1 && setup == 1) ? 1 : 0);
    if (exp_en == 1 && setup == 1) check("rd_cycle", rd_cyc, 2);
    check("start_count", st_cnt, exp_en);
    if (exp_en == 1) check("start_cycle", st_cyc, exp_st);
    check("fire_done_count", fd_cnt, 1);
    check("fire_done_cycle", fd_cyc, (exp_en == 1) ? exp_st + 1 + dly + 2 : 2);
    check("fired", fd_fired, exp_en);

    if (exp_en == 1) m_mode = (m_mode + 1) % 3;
    m_len = exp_len;
    m_cmd = exp_cmd;
    check("mode_after", mode_out, m_mode);
    check("length_after", length_out, m_len);
    check("command_after", command_out, m_cmd);
  endtask

  task automatic set_pops(input int d, input int l, input int cm, input int f);
    pop_in_data    = 5'(d);
    pop_in_length  = 5'(l);
    pop_in_command = 5'(cm);
    free_space_out = 5'(f);
  endtask

  // Reset while the child is running a SETUP firing (model mode must be 0).
  task automatic reset_mid();
    int fd_seen;
    set_pops(3, 1, 1, 1);
    length_in  = 2'd3;
    command_in = 2'd2;
    @(posedge clk); #1 invoke = 1'b1;
    @(posedge clk); #1 invoke = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("mid_latched_length", length_out, 3);
    rst = 1'b0;
    #1;
    check("mid_rst_start", start_out, 0);
    check("mid_rst_rd", rd_in_length, 0);
    check("mid_rst_fire_done", fire_done_out, 0);
    check("mid_rst_fired", fired_out, 0);
    check("mid_rst_mode", mode_out, 0);
    check("mid_rst_length", length_out, 0);
    check("mid_rst_command", command_out, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_mode = 0; m_len = 0; m_cmd = 0;
    fd_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fire_done_out || start_out) fd_seen++;
    end
    check("mid_rst_no_activity", fd_seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mode", mode_out, 0);
    check("rst_start", start_out, 0);
    check("rst_rd", {rd_in_length, rd_in_command}, 0);
    check("rst_fire_done", {fire_done_out, fired_out}, 0);
    check("rst_tokens", {length_out, command_out}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_rst", {start_out, fire_done_out, rd_in_length}, 0);

    // 1: SETUP firing at exactly size tokens
    set_pops(3, 1, 1, 0);
    do_invoke(3, 1'b0, 2'd1, 2'd2);
    // 2: COMP firing, no FIFO reads
    do_invoke(1, 1'b0, 2'd0, 2'd0);
    // 3: OUTPUT rejected on full output FIFO, then fires
    set_pops(0, 0, 0, 0);
    do_invoke(0, 1'b0, 2'd0, 2'd0);
    set_pops(0, 0, 0, 1);
    do_invoke(2, 1'b0, 2'd0, 2'd0);
    // 4: SETUP one token short, then fire with tokens held through COMP
    set_pops(2, 1, 1, 1);
    do_invoke(0, 1'b0, 2'd3, 2'd3);
    set_pops(3, 0, 1, 1);
    do_invoke(0, 1'b0, 2'd3, 2'd3);
    set_pops(3, 1, 1, 1);
    do_invoke(0, 1'b0, 2'd2, 2'd1);
    do_invoke(5, 1'b0, 2'd0, 2'd0);
    do_invoke(1, 1'b0, 2'd0, 2'd0);
    // 5: ignored invoke/done pulses around a firing
    set_pops(16, 16, 16, 16);
    do_invoke(6, 1'b1, 2'd1, 2'd3);
    do_invoke(4, 1'b1, 2'd0, 2'd0);
    do_invoke(0, 1'b1, 2'd0, 2'd0);
    // 6: reset during S_WAIT, then a clean SETUP firing
    reset_mid();
    set_pops(4, 2, 1, 0);
    do_invoke(2, 1'b0, 2'd2, 2'd2);

    // Randomized invokes biased toward the enable boundaries
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 1) == 0)
        set_pops($urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1));
      else
        set_pops($urandom_range(0, 16), $urandom_range(0, 16), $urandom_range(0, 16), $urandom_range(0, 16));
      do_invoke($urandom_range(0, 6), 1'($urandom), 2'($urandom), 2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
